or_req_sched: RTL and testbench
===============================

Name: or_req_sched

Overview:
Round-robin scheduler that shares one ifc_or operator instance between NREQ requesters. It accepts one operand pair at a time, sequences the operator's a, b and y method handshakes, and routes the result back to the owning requester. It sits between the requester clients and the ifc_or instance, replacing direct enable wiring.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 1, operand/result width; must match the operator instance
CNTW, 16, width of completed-operation counter

Ports:
CLK  input  1  system clock; all state updates on rising edge
RST_N  input  1  asynchronous reset, active-high (1 = reset, despite the suffix)
req_en  input  NREQ  per-requester request valid; data held stable until accepted
req_a  input  NREQ*WIDTH  operand a, requester i at [i*WIDTH +: WIDTH]
req_b  input  NREQ*WIDTH  operand b, same packing
req_rdy  output  NREQ  one-hot accept; transfer when req_en[i] & req_rdy[i]
resp_valid  output  NREQ  one-hot result valid to the owning requester
resp_data  output  WIDTH  result, valid while any resp_valid bit is high
resp_ack  input  NREQ  requester consumes result
or_a_data  output  WIDTH  to operator a_data
or_a_en  output  1  to operator a_en
or_a_rdy  input  1  from operator a_rdy
or_b_data  output  WIDTH  to operator b_data
or_b_en  output  1  to operator b_en
or_b_rdy  input  1  from operator b_rdy
or_y_data  input  WIDTH  from operator y_data
or_y_en  output  1  to operator y_en
or_y_rdy  input  1  from operator y_rdy
busy  output  1  state != IDLE
op_count  output  CNTW  completed operations, wraps modulo 2^CNTW

Behaviour:
- Reset, asynchronous: state=IDLE, rr_ptr=0, owner=0, a_done=b_done=0, operand/result regs=0, op_count=0. All outputs 0: req_rdy, resp_valid, or_*_en, busy. Reset mid-operation abandons the in-flight op with no response. The operator is reset by the same reset.
- FSM states: IDLE, ISSUE, WAIT_Y, RESP.
- IDLE: grant = first i with req_en[i] high, searching rr_ptr, rr_ptr+1, ..., mod NREQ. req_rdy[grant]=1 combinationally; req_rdy depends on req_en. If any request is granted: latch a, b and owner=grant; set rr_ptr=(grant+1) mod NREQ; move to ISSUE. If no request, stay in IDLE.
- ISSUE: or_a_en = or_a_rdy & ~a_done. or_b_en = or_b_rdy & ~b_done. Each enable is never asserted without its rdy. A fired enable sets its done flag. a and b may fire in the same cycle. When both are done (including the firing cycle), clear the flags and move to WAIT_Y.
- WAIT_Y: or_y_en = or_y_rdy. On fire, capture or_y_data into the result reg and move to RESP. No timeout.
- RESP: resp_valid[owner]=1 and resp_data=result. On resp_ack[owner]: op_count+1 and move to IDLE. Ack bits of other requesters are ignored. No new request is accepted in RESP; the next grant comes from IDLE the following cycle.
- Best-case latency with all operator rdy high: accept at cycle 0, ISSUE at 1, WAIT_Y at 2, RESP at 3. With ack at 3, the next accept is at 4.
- or_a_data/or_b_data are driven from the latched operands at all times.
- At most one op is in flight; requests that are not granted stay pending, with no drop and no reorder per requester.

Test Plan:
- Single op: reset, req_en=0001, a=1, b=0, operator rdy all high -> req_rdy=0001 at cycle 0; resp_valid=0001, resp_data=1 at cycle 3; op_count=1 after ack.
- Fairness: req_en=1111 held and each result acked immediately -> grant order 0,1,2,3,0; req_rdy never has more than one bit set.
- Stalled operator: hold or_b_rdy=0 for 5 cycles in ISSUE -> or_a_en pulses exactly once, state stays ISSUE; b fires when rdy rises, then WAIT_Y.
- Response backpressure: hold resp_ack low 10 cycles, req_en[2]=1 pending -> resp_valid stable, req_rdy=0; req_rdy[2]=1 the cycle after ack.
- Reset mid-op: assert RST_N while in WAIT_Y -> all outputs 0 immediately (asynchronous), op_count=0, rr_ptr=0; after release, a new request is granted normally.
- Wrap: CNTW=4, 17 ops -> op_count=1; a=0, b=0 -> resp_data=0.

Source files
------------

// File: rtl/or_req_sched_if.sv
// Bundle of the requester-side and operator-side handshakes around or_req_sched.
// The scheduler takes the slave view; requesters and the operator take the master view.
interface or_req_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 1,
  parameter int CNTW  = 16
);
  logic [NREQ-1:0]       req_en;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_rdy;
  logic [NREQ-1:0]       resp_valid;
  logic [WIDTH-1:0]      resp_data;
  logic [NREQ-1:0]       resp_ack;
  logic [WIDTH-1:0]      or_a_data;
  logic                  or_a_en;
  logic                  or_a_rdy;
  logic [WIDTH-1:0]      or_b_data;
  logic                  or_b_en;
  logic                  or_b_rdy;
  logic [WIDTH-1:0]      or_y_data;
  logic                  or_y_en;
  logic                  or_y_rdy;
  logic                  busy;
  logic [CNTW-1:0]       op_count;

  modport slave (
    input  req_en, req_a, req_b, resp_ack, or_a_rdy, or_b_rdy, or_y_data, or_y_rdy,
    output req_rdy, resp_valid, resp_data, or_a_data, or_a_en, or_b_data, or_b_en,
           or_y_en, busy, op_count
  );

  modport master (
    output req_en, req_a, req_b, resp_ack, or_a_rdy, or_b_rdy, or_y_data, or_y_rdy,
    input  req_rdy, resp_valid, resp_data, or_a_data, or_a_en, or_b_data, or_b_en,
           or_y_en, busy, op_count
  );
endinterface

// File: rtl/or_req_sched.sv
// Round-robin scheduler sharing one OR operator between NREQ requesters,
// one operation in flight, result routed back to the granted requester.
module or_req_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 1,
  parameter int CNTW  = 16
) (
  input logic           CLK,
  input logic           RST_N,
  or_req_sched_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_Y, RESP} state_t;

  state_t           state;
  logic [PW-1:0]    rr_ptr, owner, grant;
  logic             grant_vld, a_done, b_done, a_fire, b_fire, y_fire;
  logic [WIDTH-1:0] opa, opb, res, sel_a, sel_b;
  logic [CNTW-1:0]  op_count;

  // First requesting index at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant     = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!grant_vld && bus.req_en[idx]) begin
        grant_vld = 1'b1;
        grant     = PW'(idx);
      end
    end
  end

  assign sel_a  = bus.req_a[int'(grant)*WIDTH +: WIDTH];
  assign sel_b  = bus.req_b[int'(grant)*WIDTH +: WIDTH];
  assign a_fire = (state == ISSUE) && bus.or_a_rdy && !a_done;
  assign b_fire = (state == ISSUE) && bus.or_b_rdy && !b_done;
  assign y_fire = (state == WAIT_Y) && bus.or_y_rdy;

  // req_rdy is combinational on req_en, so it is masked while reset is held.
  for (genvar i = 0; i < NREQ; i++) begin : g_req
    assign bus.req_rdy[i]    = !RST_N && (state == IDLE) && grant_vld && (grant == PW'(i));
    assign bus.resp_valid[i] = (state == RESP) && (owner == PW'(i));
  end

  assign bus.resp_data = res;
  assign bus.or_a_data = opa;
  assign bus.or_b_data = opb;
  assign bus.or_a_en   = a_fire;
  assign bus.or_b_en   = b_fire;
  assign bus.or_y_en   = y_fire;
  assign bus.busy      = (state != IDLE);
  assign bus.op_count  = op_count;

  always_ff @(posedge CLK or posedge RST_N) begin
    if (RST_N) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      a_done   <= 1'b0;
      b_done   <= 1'b0;
      opa      <= '0;
      opb      <= '0;
      res      <= '0;
      op_count <= '0;
    end else begin
      case (state)
        IDLE: if (grant_vld) begin
          opa    <= sel_a;
          opb    <= sel_b;
          owner  <= grant;
          rr_ptr <= PW'((int'(grant) + 1) % NREQ);
          state  <= ISSUE;
        end
        ISSUE: begin
          // Both halves may land in the same cycle; done flags cover split arrival.
          if ((a_done || a_fire) && (b_done || b_fire)) begin
            a_done <= 1'b0;
            b_done <= 1'b0;
            state  <= WAIT_Y;
          end else begin
            a_done <= a_done || a_fire;
            b_done <= b_done || b_fire;
          end
        end
        WAIT_Y: if (y_fire) begin
          res   <= bus.or_y_data;
          state <= RESP;
        end
        RESP: if (bus.resp_ack[owner]) begin
          op_count <= op_count + CNTW'(1);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_or_req_sched.sv
// Directed bench for or_req_sched: table of full operations plus stall,
// backpressure, mid-op reset and counter-wrap sequences.
module tb_or_req_sched;
  localparam int NREQ = 4, WIDTH = 4, CNTW = 4;

  logic CLK, RST_N;
  int   checks = 0, failures = 0;
  logic [3:0] exp_cnt;
  logic [3:0] m_a, m_b;

  or_req_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW)) bus ();
  or_req_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus.slave));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Operator stand-in: latch a and b on their enables, y = a | b.
  always_ff @(posedge CLK or posedge RST_N) begin
    if (RST_N) begin
      m_a <= '0;
      m_b <= '0;
    end else begin
      if (bus.or_a_en) m_a <= bus.or_a_data;
      if (bus.or_b_en) m_b <= bus.or_b_data;
    end
  end
  assign bus.or_y_data = m_a | m_b;

  typedef struct {
    logic [3:0]  en;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  g;
    logic [3:0]  d;
  } vec_t;
  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Entered at posedge+1 with the DUT idle; leaves at posedge+1 after the ack edge.
  task automatic run_op(input logic [3:0] en, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] g, input logic [3:0] d);
    bus.req_en = en; bus.req_a = a; bus.req_b = b;
    @(negedge CLK);
    chk("grant", bus.req_rdy, g);
    chk("onehot", ($countones(bus.req_rdy) <= 1), 1);
    chk("idle_busy", bus.busy, 0);
    @(posedge CLK); #1; bus.req_en = '0;
    @(negedge CLK);
    chk("c1_vld", bus.resp_valid, 0);
    chk("c1_busy", bus.busy, 1);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("c2_vld", bus.resp_valid, 0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("resp_vld", bus.resp_valid, g);
    chk("resp_data", bus.resp_data, d);
    bus.resp_ack = g;
    @(posedge CLK); #1;
    bus.resp_ack = '0;
    exp_cnt = exp_cnt + 4'd1;
    chk("op_count", bus.op_count, exp_cnt);
  endtask

  initial begin
    int n_a;
    vt[0] = '{4'b0001, 16'h0001, 16'h0000, 4'b0001, 4'h1};
    vt[1] = '{4'b1111, 16'h4321, 16'h8888, 4'b0010, 4'hA};
    vt[2] = '{4'b1111, 16'h4321, 16'h8888, 4'b0100, 4'hB};
    vt[3] = '{4'b1111, 16'h4321, 16'h8888, 4'b1000, 4'hC};
    vt[4] = '{4'b1111, 16'h4321, 16'h8888, 4'b0001, 4'h9};
    vt[5] = '{4'b0001, 16'h4321, 16'h8888, 4'b0001, 4'h9};
    vt[6] = '{4'b0101, 16'h0F00, 16'h00F0, 4'b0100, 4'hF};
    vt[7] = '{4'b0011, 16'h0056, 16'h00A1, 4'b0001, 4'h7};
    vt[8] = '{4'b0011, 16'h0056, 16'h00A1, 4'b0010, 4'hF};
    vt[9] = '{4'b1000, 16'h7000, 16'h0000, 4'b1000, 4'h7};

    RST_N = 1'b1;
    bus.req_en = 4'b1111; bus.req_a = '0; bus.req_b = '0; bus.resp_ack = '0;
    bus.or_a_rdy = 1'b1; bus.or_b_rdy = 1'b1; bus.or_y_rdy = 1'b1;
    exp_cnt = '0;
    #3;
    chk("rst_rdy", bus.req_rdy, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_vld", bus.resp_valid, 0);
    chk("rst_aen", bus.or_a_en, 0);
    chk("rst_cnt", bus.op_count, 0);
    @(negedge CLK); @(negedge CLK);
    bus.req_en = '0; RST_N = 1'b0;
    @(posedge CLK); #1;

    for (int i = 0; i < 10; i++) run_op(vt[i].en, vt[i].a, vt[i].b, vt[i].g, vt[i].d);

    // Stalled b: a fires once, state holds in ISSUE, then b completes.
    bus.or_b_rdy = 1'b0;
    bus.req_en = 4'b0010; bus.req_a = 16'h0030; bus.req_b = 16'h0040;
    @(negedge CLK);
    chk("stall_grant", bus.req_rdy, 4'b0010);
    @(posedge CLK); #1; bus.req_en = '0;
    n_a = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      n_a += int'(bus.or_a_en);
      chk("stall_ben", bus.or_b_en, 0);
      chk("stall_yen", bus.or_y_en, 0);
      chk("stall_busy", bus.busy, 1);
      @(posedge CLK); #1;
    end
    chk("stall_a_once", n_a, 1);
    bus.or_b_rdy = 1'b1;
    @(negedge CLK);
    chk("stall_bfire", bus.or_b_en, 1);
    chk("stall_anofire", bus.or_a_en, 0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("stall_waity", bus.or_y_en, 1);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("stall_vld", bus.resp_valid, 4'b0010);
    chk("stall_data", bus.resp_data, 4'h7);

    // Response held: pending request waits, foreign acks ignored.
    bus.req_en = 4'b0100; bus.req_a = 16'h0500; bus.req_b = 16'h0A00;
    for (int c = 0; c < 10; c++) begin
      @(posedge CLK); #1;
      bus.resp_ack = (c % 2 == 1) ? 4'b0100 : 4'b0000;
      @(negedge CLK);
      chk("bp_vld", bus.resp_valid, 4'b0010);
      chk("bp_data", bus.resp_data, 4'h7);
      chk("bp_rdy", bus.req_rdy, 0);
    end
    @(posedge CLK); #1; bus.resp_ack = 4'b0010;
    @(posedge CLK); #1; bus.resp_ack = '0;
    exp_cnt = exp_cnt + 4'd1;
    chk("bp_cnt", bus.op_count, exp_cnt);
    chk("bp_next_rdy", bus.req_rdy, 4'b0100);
    run_op(4'b0100, 16'h0500, 16'h0A00, 4'b0100, 4'hF);

    // Reset while parked in WAIT_Y.
    bus.or_y_rdy = 1'b0;
    bus.req_en = 4'b1000; bus.req_a = 16'h9000; bus.req_b = 16'h0000;
    @(negedge CLK);
    chk("mr_grant", bus.req_rdy, 4'b1000);
    @(posedge CLK); #1; bus.req_en = '0;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("mr_waity", bus.or_y_en, 0);
    chk("mr_busy", bus.busy, 1);
    bus.req_en = 4'b1111; bus.or_y_rdy = 1'b1;
    #2 RST_N = 1'b1;
    #1;
    chk("mr_busy0", bus.busy, 0);
    chk("mr_rdy0", bus.req_rdy, 0);
    chk("mr_vld0", bus.resp_valid, 0);
    chk("mr_yen0", bus.or_y_en, 0);
    chk("mr_cnt0", bus.op_count, 0);
    exp_cnt = '0;
    @(posedge CLK); #1;
    chk("mr_rdy_held", bus.req_rdy, 0);
    bus.req_en = '0;
    @(negedge CLK); RST_N = 1'b0;
    @(posedge CLK); #1;
    run_op(4'b1111, 16'h1236, 16'h0009, 4'b0001, 4'hF);

    // Counter wrap with 4-bit op_count.
    @(negedge CLK); RST_N = 1'b1;
    @(negedge CLK); RST_N = 1'b0;
    exp_cnt = '0;
    @(posedge CLK); #1;
    for (int i = 0; i < 17; i++) run_op(4'b0001, 16'h0000, 16'h0000, 4'b0001, 4'h0);
    chk("wrap_cnt", bus.op_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule
